beat_rate_divider: RTL
======================

// Module: beat_rate_divider
// PURPOSE
//   Programmable rate divider / beat sequencer that produces the one-cycle enable pulses feeding the
//   8-bit beat counter (its enable input), paced from the 50 MHz system clock.
//   Start/stop/pause control for song playback, optional beat limit with a done pulse at song end.
//   Sits directly upstream of the counter; tick drives counter enable, beat_count mirrors its value.
// PARAMETERS
//   WIDTH          28            divider width in bits; period range 0 .. 2^WIDTH-1
//   DEFAULT_PERIOD 28'd12499999  period_reg value after reset (4 ticks/s at 50 MHz)
// PORTS
//   Interface: one clock; reset is asynchronous and active-high.
//   clock        in   1      system clock, all state on rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      1-cycle request: clear beat_count, load divider, enter RUN
//   stop         in   1      1-cycle request: return to IDLE
//   pause        in   1      level; while 1 in RUN/PAUSE the divider freezes
//   load_period  in   1      1-cycle strobe: period_reg <= period_in
//   period_in    in   WIDTH  new period P; tick spacing = P+1 clock cycles
//   beat_limit   in   8      beats until done; 0 = free-run (no limit)
//   tick         out  1      registered 1-cycle pulse; counter enable
//   beat_count   out  8      ticks issued since last start, registered
//   running      out  1      1 in RUN or PAUSE
//   done         out  1      registered 1-cycle pulse when beat_limit reached
// BEHAVIOUR
// - Reset (async, any time incl. mid-run): state=IDLE, div=0, tick=0, done=0, beat_count=0,
//   running=0, period_reg=DEFAULT_PERIOD. Takes effect immediately, no clock needed.
// - FSM states IDLE, RUN, PAUSE, DONE. Priority per edge: stop > start > pause > divider.
//   IDLE : start -> RUN. Other inputs ignored except load_period.
//   RUN  : stop -> IDLE; start -> restart (RUN); pause=1 -> PAUSE; else count.
//   PAUSE: stop -> IDLE; start -> restart (RUN); pause=0 -> RUN. div and beat_count frozen, no tick.
//   DONE : one cycle only, done=1, then IDLE unconditionally (start here is ignored).
// - Start, sampled at edge E0: div<=P (P = period_in if load_period same edge, else period_reg),
//   beat_count<=0, state<=RUN. Restart from RUN/PAUSE behaves identically.
// - RUN count: div!=0 -> div<=div-1. div==0 -> tick<=1, div<=period_reg, beat_count<=beat_count+1.
//   First tick high in the cycle after edge E(P+1); subsequent ticks every P+1 cycles. P=0 -> tick
//   every cycle while RUN.
// - tick and done are 0 in every cycle not explicitly set above; both are single-cycle pulses.
// - beat_count is 8-bit unsigned, wraps 255 -> 0 when beat_limit=0. Holds value in IDLE/PAUSE/DONE;
//   stop does not clear it; only start or reset clear it.
// - Limit: on the tick edge where beat_count+1 == beat_limit (limit != 0): tick<=1, beat_count
//   updated, state<=DONE, done<=1 in the same cycle as that final tick. running=0 from then on.
// - load_period: period_reg updated any state, any time; a running countdown is not disturbed,
//   new value used at the next reload. beat_limit sampled live each tick edge.
// - pause asserted on the same edge div==0 in RUN: pause wins, no tick; the tick issues on the first
//   RUN edge after resume (div still 0).
// - running = (state==RUN || state==PAUSE), registered with state.
// TESTING
//   1 reset mid-RUN (div=5, beat_count=3) -> all outputs 0 asynchronously, period_reg=DEFAULT_PERIOD.
//   2 load_period P=3 + start, limit 0 -> tick every 4 cycles, first after 4 edges; count 1,2,3...
//     run 260 ticks -> beat_count wraps 255->0->4.
//   3 P=0, beat_limit=3, start -> ticks 3 consecutive cycles, done=1 with third tick, running=0, IDLE.
//   4 P=4, pause 1 for 10 cycles mid-count -> no tick, div/beat_count frozen; tick spacing resumes
//     exactly where it stopped.
//   5 start and stop same cycle in RUN -> IDLE, beat_count unchanged; start alone in PAUSE -> count=0.
//   6 load_period P=9 while RUN at P=2 -> current interval stays 3 cycles, following intervals 10.

Source files
------------

// File: rtl/beat_rate_divider.sv
// beat_rate_divider: programmable rate divider and beat sequencer.
// Produces single-cycle tick pulses that enable the downstream beat counter.
// The start/stop/pause controls drive playback, and an optional beat limit
// ends the song with a done pulse.
module beat_rate_divider #(
    parameter int unsigned      WIDTH          = 28,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 28'd12499999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             load_period,
    input  logic [WIDTH-1:0] period_in,
    input  logic [7:0]       beat_limit,
    output logic             tick,
    output logic [7:0]       beat_count,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] period_q;
    logic [7:0]       beat_q;
    logic             tick_q;
    logic             done_q;
    logic             running_q;

    logic [WIDTH-1:0] start_div_d;
    logic [7:0]       beat_d;
    logic             limit_hit_d;

    // Start-load value, incremented beat and limit detection for the current edge.
    // A period loaded on the same edge as start takes effect immediately.
    always_comb begin
        start_div_d = load_period ? period_in : period_q;
        beat_d      = beat_q + 8'd1;
        limit_hit_d = (beat_limit != 8'd0) && (beat_d == beat_limit);
    end

    // Playback FSM. Priority on each edge is stop > start > pause > divider.
    // tick and done default low, so each is a one-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            period_q  <= DEFAULT_PERIOD;
            beat_q    <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;

            // The period register is writable in every state. A countdown that
            // is already running picks up the new value at its next reload.
            if (load_period) begin
                period_q <= period_in;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        div_q     <= start_div_d;
                        beat_q    <= '0;
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end

                ST_RUN, ST_PAUSE: begin
                    if (stop) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (start) begin
                        div_q     <= start_div_d;
                        beat_q    <= '0;
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (state_q == ST_PAUSE) begin
                        // The resume edge only changes state. The divider
                        // counts again from the following edge.
                        if (!pause) begin
                            state_q <= ST_RUN;
                        end
                    end else if (pause) begin
                        state_q <= ST_PAUSE;
                    end else if (div_q != '0) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        tick_q <= 1'b1;
                        div_q  <= period_q;
                        beat_q <= beat_d;
                        if (limit_hit_d) begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            running_q <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick       = tick_q;
    assign done       = done_q;
    assign beat_count = beat_q;
    assign running    = running_q;

endmodule
